// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM states and default widths.
package clk_period_meter_pkg;

    localparam int DEFAULT_CNT_W       = 12;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

endpackage

// File: rtl/clk_period_meter_if.sv
// Control and result bundle of the clock period meter.
interface clk_period_meter_if
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;

    modport master (
        output en,
        output sig_in,
        input  period,
        input  high_time,
        input  meas_valid,
        input  timeout
    );

    modport slave (
        input  en,
        input  sig_in,
        output period,
        output high_time,
        output meas_valid,
        output timeout
    );

endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus one-cycle rise/fall strobes.
module sync_edge_det
    import clk_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sDly_q;

    // Stage 0 samples the raw input; the last stage is the usable synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sDly_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            sDly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~sDly_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & sDly_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// with a one-cycle valid strobe per period and a sticky timeout for a stalled input.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst_n,
    clk_period_meter_if.slave   bus
);

    // Last count value before the counter would reach its all-ones maximum.
    localparam logic [CNT_W-1:0] CNT_LIMIT = {{(CNT_W-1){1'b1}}, 1'b0};

    logic             rise;
    logic             fall;
    state_e           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] hiCap_q,      hiCap_d;
    logic [CNT_W-1:0] period_q,     period_d;
    logic [CNT_W-1:0] highTime_q,   highTime_d;
    logic             measValid_q,  measValid_d;
    logic             timeout_q,    timeout_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.sig_in),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        hiCap_d     = hiCap_q;
        period_d    = period_q;
        highTime_d  = highTime_q;
        measValid_d = 1'b0;
        timeout_d   = timeout_q;

        if (!bus.en) begin
            state_d = IDLE;
            hiCap_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
                        hiCap_d = '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d    = cnt_q + 1'b1;
                        highTime_d  = hiCap_q;
                        measValid_d = 1'b1;
                        timeout_d   = 1'b0;
                        hiCap_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (fall) begin
                            hiCap_d = cnt_q + 1'b1;
                        end
                        // A rise on the limit cycle still publishes; only its absence times out.
                        if (cnt_q == CNT_LIMIT) begin
                            timeout_d = 1'b1;
                            state_d   = ARM;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hiCap_q     <= '0;
            period_q    <= '0;
            highTime_q  <= '0;
            measValid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hiCap_q     <= hiCap_d;
            period_q    <= period_d;
            highTime_q  <= highTime_d;
            measValid_q <= measValid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = highTime_q;
    assign bus.meas_valid = measValid_q;
    assign bus.timeout    = timeout_q;

endmodule
